// File: rtl/cpu_run_monitor_pkg.sv
// Shared definitions for the CPU run monitor.
// Holds the run-controller state encoding and the default channel width so
// the top level, its sub-module and any neighbouring blocks agree on them.
package cpu_run_monitor_pkg;

  // State codes are fixed so that external tools can decode the state.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_t;

  localparam int DEFAULT_DATA_W = 32;

  // Width needed to hold any value 0..max_val (never less than one bit).
  function automatic int count_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_run_monitor_stability.sv
// Stability detector for the CPU run monitor.
// Remembers the previous sample of all watched channels and counts how many
// consecutive samples matched it. 'stable' pulses in the cycle where the
// STABLE_CYCLES-th identical sample arrives.
// Ports:
//   clk    in  1      clock, posedge
//   clear  in  1      synchronous clear of history (reset or not running)
//   sample in  WIDTH  all watched channels, packed
//   stable out 1      combinational pulse: finish condition met this cycle
module stability_detector
  import cpu_run_monitor_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] sample,
  output logic             stable
);

  // Counter only ever reaches STABLE_CYCLES-1 before the run leaves RUN.
  localparam int SC_W = count_width(STABLE_CYCLES);

  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic [SC_W-1:0]  stable_cnt;
  logic             eq;

  // The very first sample has nothing to compare against, so it never
  // counts as stable.
  assign eq     = prev_valid && (sample == prev);
  assign stable = eq && (stable_cnt == SC_W'(STABLE_CYCLES - 2));

  always_ff @(posedge clk) begin
    if (clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      stable_cnt <= '0;
    end else begin
      prev       <= sample;
      prev_valid <= 1'b1;
      stable_cnt <= eq ? stable_cnt + SC_W'(1) : '0;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// CPU run controller / monitor.
// Holds the CPU core in reset for RST_HOLD cycles, then lets it run while
// counting cycles and watching NUM_CH result registers. When all channels
// hold steady for STABLE_CYCLES samples the run is finished and the final
// values are compared with expect_val; if the budget of MAX_CYCLES runs out
// first, a timeout is flagged instead.
// Ports:
//   Clk           in   1              clock, posedge
//   Reset         in   1              synchronous, active-high
//   watch         in   NUM_CH*DATA_W  watched channels, ch i at [i*DATA_W +: DATA_W]
//   expect_val    in   NUM_CH*DATA_W  expected final values, same packing
//   core_rst      out  1              reset to the CPU core
//   running       out  1              high while the core runs
//   done          out  1              sticky: finish condition met
//   pass          out  1              sticky: finished and all channels matched
//   timeout       out  1              sticky: budget exhausted without finish
//   mismatch_mask out  NUM_CH         per-channel mismatch at finish
//   cycle_count   out  CNT_W          run cycles elapsed, frozen afterwards
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int CNT_W         = 32,
  parameter int RST_HOLD      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_CYCLES    = 10000,
  parameter int HALT_ON_DONE  = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_CH*DATA_W-1:0] watch,
  input  logic [NUM_CH*DATA_W-1:0] expect_val,
  output logic                     core_rst,
  output logic                     running,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [NUM_CH-1:0]        mismatch_mask,
  output logic [CNT_W-1:0]         cycle_count
);

  localparam int HOLD_W = count_width(RST_HOLD);
  localparam logic HALT = (HALT_ON_DONE != 0);

  run_state_t        state;
  run_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              stable;
  logic              budget_hit;
  logic [NUM_CH-1:0] ch_diff;

  // History is discarded whenever the core is not running, so every run
  // starts its stability count from scratch.
  stability_detector #(
    .WIDTH         (NUM_CH * DATA_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable (
    .clk    (Clk),
    .clear  (Reset || (state != ST_RUN)),
    .sample (watch),
    .stable (stable)
  );

  // Per-channel comparison of the live values against the expected ones;
  // only captured on the cycle the run finishes.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
    assign ch_diff[i] = (watch[i*DATA_W +: DATA_W] != expect_val[i*DATA_W +: DATA_W]);
  end

  // This cycle is the last one the budget allows.
  assign budget_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_HOLD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Finishing is checked before the budget so that a
  // finish landing on the final budget cycle still counts as done.
  always_comb begin
    state_next = state;
    case (state)
      ST_HOLD: if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state_next = ST_RUN;
      ST_RUN: begin
        if (stable) begin
          state_next = ST_DONE;
        end else if (budget_hit) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: state_next = state;
    endcase
  end

  // Registered outputs and counters, all derived from the upcoming state so
  // they line up with the state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_cnt      <= '0;
      core_rst      <= 1'b1;
      running       <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      mismatch_mask <= '0;
      cycle_count   <= '0;
    end else begin
      if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (state == ST_RUN) begin
        cycle_count <= cycle_count + CNT_W'(1);
        if (stable) begin
          done          <= 1'b1;
          mismatch_mask <= ch_diff;
          pass          <= ~|ch_diff;
        end else if (budget_hit) begin
          timeout <= 1'b1;
        end
      end
      running  <= (state_next == ST_RUN);
      core_rst <= (state_next == ST_HOLD) ||
                  (((state_next == ST_DONE) || (state_next == ST_TIMEOUT)) && HALT);
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor.
// A run-level reference model tracks hold length, trailing run length of
// identical samples and the run-cycle budget, and is compared against the
// design on every falling edge. Directed scenarios add literal checks.
module tb_cpu_run_monitor;

  localparam int NUM_CH   = 2;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 32;
  localparam int RST_HOLD = 4;
  localparam int STABLE   = 16;
  localparam int MAXC     = 100;
  localparam int HALT     = 1;

  localparam int PH_HOLD = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_END  = 2;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic [NUM_CH*DATA_W-1:0] watch;
  logic [NUM_CH*DATA_W-1:0] expect_val;
  logic                     core_rst;
  logic                     running;
  logic                     done;
  logic                     pass;
  logic                     timeout;
  logic [NUM_CH-1:0]        mismatch_mask;
  logic [CNT_W-1:0]         cycle_count;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  // Reference model state.
  int                       m_phase = PH_HOLD;
  int                       m_hold_seen = 0;
  int                       m_run_len = 0;
  int                       m_count = 0;
  logic [NUM_CH*DATA_W-1:0] m_last = '0;
  logic                     m_core_rst = 1'b1;
  logic                     m_running = 1'b0;
  logic                     m_done = 1'b0;
  logic                     m_pass = 1'b0;
  logic                     m_timeout = 1'b0;
  logic [NUM_CH-1:0]        m_mask = '0;

  cpu_run_monitor #(
    .NUM_CH        (NUM_CH),
    .DATA_W        (DATA_W),
    .CNT_W         (CNT_W),
    .RST_HOLD      (RST_HOLD),
    .STABLE_CYCLES (STABLE),
    .MAX_CYCLES    (MAXC),
    .HALT_ON_DONE  (HALT)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .watch         (watch),
    .expect_val    (expect_val),
    .core_rst      (core_rst),
    .running       (running),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .mismatch_mask (mismatch_mask),
    .cycle_count   (cycle_count)
  );

  initial forever #5 Clk = ~Clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One model step per rising edge: the run finishes once the trailing
  // stretch of identical samples reaches STABLE, or times out after MAXC
  // run cycles, whichever comes first.
  task automatic model_step();
    if (Reset) begin
      m_phase = PH_HOLD; m_hold_seen = 0; m_run_len = 0; m_count = 0;
      m_core_rst = 1'b1; m_running = 1'b0; m_done = 1'b0; m_pass = 1'b0;
      m_timeout = 1'b0; m_mask = '0;
    end else begin
      case (m_phase)
        PH_HOLD: begin
          m_hold_seen++;
          if (m_hold_seen == RST_HOLD) begin
            m_phase = PH_RUN; m_core_rst = 1'b0; m_running = 1'b1;
          end
        end
        PH_RUN: begin
          m_count++;
          if (m_run_len > 0 && watch == m_last) m_run_len++;
          else m_run_len = 1;
          m_last = watch;
          if (m_run_len >= STABLE) begin
            for (int c = 0; c < NUM_CH; c++)
              m_mask[c] = (watch[c*DATA_W +: DATA_W] != expect_val[c*DATA_W +: DATA_W]);
            m_done = 1'b1; m_pass = (m_mask == '0);
            m_phase = PH_END; m_running = 1'b0; m_core_rst = (HALT != 0);
          end else if (m_count == MAXC) begin
            m_timeout = 1'b1;
            m_phase = PH_END; m_running = 1'b0; m_core_rst = (HALT != 0);
          end
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  // Continuous comparison against the model on every falling edge.
  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      check_output("core_rst", core_rst, m_core_rst);
      check_output("running", running, m_running);
      check_output("done", done, m_done);
      check_output("pass", pass, m_pass);
      check_output("timeout", timeout, m_timeout);
      check_output("mismatch_mask", mismatch_mask, m_mask);
      check_output("cycle_count", cycle_count, 64'(m_count));
    end
  end

  task automatic apply_stimulus(input logic [31:0] w0, input logic [31:0] w1);
    watch = {w1, w0};
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_running(output int n);
    n = 0;
    while (!running && n < 20) begin
      apply_stimulus(32'd0, 32'd0);
      n++;
    end
    check_output("running_after_hold", running, 1);
  endtask

  task automatic restart();
    int n;
    Reset = 1'b1;
    apply_stimulus(32'd0, 32'd0);
    Reset = 1'b0;
    wait_running(n);
    check_output("hold_cycles", n, RST_HOLD);
  endtask

  // ch0 changes on run cycles 1..19, reaches 7 on cycle 20 and holds; ch1 holds 3.
  task automatic run_settle(input logic [31:0] e0, input logic [31:0] e1,
                            input logic exp_pass, input logic [1:0] exp_mask);
    expect_val = {e1, e0};
    for (int i = 1; i <= 19; i++) apply_stimulus(32'(100 + i), 32'd3);
    for (int i = 20; i <= 34; i++) apply_stimulus(32'd7, 32'd3);
    check_output("settle_not_done_34", done, 0);
    apply_stimulus(32'd7, 32'd3);
    check_output("settle_done_35", done, 1);
    check_output("settle_count_35", cycle_count, 35);
    check_output("settle_pass", pass, exp_pass);
    check_output("settle_mask", mismatch_mask, exp_mask);
    check_output("settle_core_rst", core_rst, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(32'd9, 32'd9);
    check_output("settle_frozen_count", cycle_count, 35);
    check_output("settle_frozen_running", running, 0);
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    watch = '0;
    expect_val = '0;

    // Reset held for three cycles, then core reset sequencing.
    apply_stimulus(32'd0, 32'd0);
    chk_en = 1'b1;
    apply_stimulus(32'd0, 32'd0);
    apply_stimulus(32'd0, 32'd0);
    check_output("reset_core_rst", core_rst, 1);
    check_output("reset_count", cycle_count, 0);
    Reset = 1'b0;
    wait_running(n);
    check_output("t1_hold_cycles", n, RST_HOLD);
    check_output("t1_core_rst_low", core_rst, 0);

    // Settles and matches.
    run_settle(32'd7, 32'd3, 1'b1, 2'b00);

    // Settles with ch1 wrong.
    restart();
    run_settle(32'd7, 32'd4, 1'b0, 2'b10);

    // Never settles: budget runs out.
    restart();
    for (int i = 1; i <= 99; i++) apply_stimulus(32'(i % 2), 32'd0);
    check_output("t4_no_timeout_99", timeout, 0);
    apply_stimulus(32'd0, 32'd0);
    check_output("t4_timeout", timeout, 1);
    check_output("t4_count", cycle_count, 100);
    check_output("t4_done", done, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(32'(i), 32'd0);
    check_output("t4_frozen_count", cycle_count, 100);

    // Finish lands exactly on the last budget cycle: done wins.
    restart();
    expect_val = {32'd0, 32'd170};
    for (int i = 1; i <= 84; i++) apply_stimulus(32'(i), 32'd0);
    for (int i = 85; i <= 100; i++) apply_stimulus(32'd170, 32'd0);
    check_output("t5_done", done, 1);
    check_output("t5_timeout", timeout, 0);
    check_output("t5_pass", pass, 1);
    check_output("t5_count", cycle_count, 100);

    // One sample short of finishing on the last cycle: timeout instead.
    restart();
    for (int i = 1; i <= 85; i++) apply_stimulus(32'(i), 32'd0);
    for (int i = 86; i <= 100; i++) apply_stimulus(32'd170, 32'd0);
    check_output("t5b_done", done, 0);
    check_output("t5b_timeout", timeout, 1);

    // Reset pulse in the middle of a run.
    restart();
    for (int i = 1; i <= 49; i++) apply_stimulus(32'(i % 2), 32'd0);
    check_output("t6_count_49", cycle_count, 49);
    Reset = 1'b1;
    apply_stimulus(32'd1, 32'd0);
    check_output("t6_core_rst", core_rst, 1);
    check_output("t6_running", running, 0);
    check_output("t6_count_cleared", cycle_count, 0);
    Reset = 1'b0;
    wait_running(n);
    check_output("t6_hold_cycles", n, RST_HOLD);
    run_settle(32'd7, 32'd3, 1'b1, 2'b00);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
